lock_search_ctrl: RTL and testbench

- Sequencer and controller for the PCMA lock-calculation datapath.
- Accepts boundary-histogram frames from upstream and issues one start pulse per frame to the lock calculator, with the candidate modulation mode.
- Applies hit/miss hysteresis to the per-frame lock flags and steps through modes (fm4 / fm8) while unlocked.
- Publishes the final locked status and the detected mode to the rest of the detector.

---
 rtl/lock_search_ctrl.sv | 179 +++++++++++++++++
 tb/tb_lock_search_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_search_ctrl.sv
// lock_search_ctrl: frame sequencer and hit/miss lock hysteresis with fm4/fm8 mode search.
// Optional statistics counters are built only when LOCK_SEARCH_STATS_EN is defined.
module lock_search_ctrl #(
  parameter int MODE_W  = 3,
  parameter int CNT_W   = 4,
  parameter int DWELL   = 4,
  parameter int TIMEOUT = 32,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic              hist_val_i,
  output logic              hist_rdy_o,
  output logic              hist_clr_o,
  output logic              calc_start_o,
  output logic [MODE_W-1:0] calc_mode_o,
  input  logic              calc_val_i,
  input  logic              calc_lock_i,
  input  logic [CNT_W-1:0]  lock_thr_i,
  input  logic [CNT_W-1:0]  unlock_thr_i,
  output logic              locked_o,
  output logic [MODE_W-1:0] mode_o,
  output logic              timeout_o,
  output logic [STAT_W-1:0] frame_cnt_o,
  output logic [STAT_W-1:0] loss_cnt_o
);

  localparam logic [MODE_W-1:0] FM4 = MODE_W'(1);
  localparam logic [MODE_W-1:0] FM8 = MODE_W'(2);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  // The timeout flag is registered, so expiry is decided one cycle early and
  // the pulse lands exactly TIMEOUT cycles after calc_start_o.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 2);

  typedef enum logic [2:0] {IDLE, WAIT_HIST, START, WAIT_RES, UPDATE} state_t;

  state_t            state_reg, state_next;
  logic [TMO_W-1:0]  tmo_cnt_reg, tmo_cnt_next;
  logic              hit_reg, hit_next;
  logic [CNT_W-1:0]  hit_cnt_reg, hit_cnt_next;
  logic [CNT_W-1:0]  miss_cnt_reg, miss_cnt_next;
  logic              locked_reg, locked_next;
  logic [MODE_W-1:0] mode_reg, mode_next;
  logic              timeout_reg, timeout_next;
  logic [31:0]       hit_inc, miss_inc, lock_lim, unlock_lim;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      tmo_cnt_reg  <= '0;
      hit_reg      <= 1'b0;
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
      locked_reg   <= 1'b0;
      mode_reg     <= FM4;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tmo_cnt_reg  <= tmo_cnt_next;
      hit_reg      <= hit_next;
      hit_cnt_reg  <= hit_cnt_next;
      miss_cnt_reg <= miss_cnt_next;
      locked_reg   <= locked_next;
      mode_reg     <= mode_next;
      timeout_reg  <= timeout_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    tmo_cnt_next  = tmo_cnt_reg;
    hit_next      = hit_reg;
    hit_cnt_next  = hit_cnt_reg;
    miss_cnt_next = miss_cnt_reg;
    locked_next   = locked_reg;
    mode_next     = mode_reg;
    timeout_next  = 1'b0;
    hit_inc       = 32'(hit_cnt_reg) + 32'd1;
    miss_inc      = 32'(miss_cnt_reg) + 32'd1;
    lock_lim      = (lock_thr_i == '0) ? 32'd1 : 32'(lock_thr_i);
    unlock_lim    = (unlock_thr_i == '0) ? 32'd1 : 32'(unlock_thr_i);
    hist_rdy_o    = (state_reg == WAIT_HIST);
    calc_start_o  = (state_reg == START);
    hist_clr_o    = (state_reg == START);

    case (state_reg)
      IDLE:      if (en_i) state_next = WAIT_HIST;
      WAIT_HIST: if (hist_val_i) state_next = START;
      START: begin
        tmo_cnt_next = '0;
        state_next   = WAIT_RES;
      end
      WAIT_RES: begin
        tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
        if (calc_val_i) begin
          hit_next   = calc_lock_i;
          state_next = UPDATE;
        end else if (tmo_cnt_reg == TMO_LAST) begin
          hit_next     = 1'b0;
          timeout_next = 1'b1;
          state_next   = UPDATE;
        end
      end
      UPDATE: begin
        state_next = WAIT_HIST;
        if (!locked_reg) begin
          if (hit_reg) begin
            miss_cnt_next = '0;
            if (hit_inc >= lock_lim) begin
              locked_next  = 1'b1;
              hit_cnt_next = '0;
            end else begin
              hit_cnt_next = sat_inc(hit_cnt_reg);
            end
          end else begin
            hit_cnt_next = '0;
            if (miss_inc >= 32'(DWELL)) begin
              mode_next     = (mode_reg == FM4) ? FM8 : FM4;
              miss_cnt_next = '0;
            end else begin
              miss_cnt_next = sat_inc(miss_cnt_reg);
            end
          end
        end else if (hit_reg) begin
          miss_cnt_next = '0;
        end else if (miss_inc >= unlock_lim) begin
          // Lock lost: search resumes from the mode we were locked on.
          locked_next   = 1'b0;
          hit_cnt_next  = '0;
          miss_cnt_next = '0;
        end else begin
          miss_cnt_next = sat_inc(miss_cnt_reg);
        end
      end
      default: state_next = IDLE;
    endcase

    if (!en_i) begin
      state_next    = IDLE;
      locked_next   = 1'b0;
      hit_cnt_next  = '0;
      miss_cnt_next = '0;
      timeout_next  = 1'b0;
    end
  end

  assign locked_o    = locked_reg;
  assign mode_o      = mode_reg;
  assign calc_mode_o = mode_reg;
  assign timeout_o   = timeout_reg;

`ifdef LOCK_SEARCH_STATS_EN
  logic [STAT_W-1:0] frame_cnt_reg, loss_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_reg <= '0;
      loss_cnt_reg  <= '0;
    end else begin
      if (state_reg == UPDATE && en_i && !(&frame_cnt_reg))
        frame_cnt_reg <= frame_cnt_reg + STAT_W'(1);
      if (locked_reg && !locked_next && !(&loss_cnt_reg))
        loss_cnt_reg <= loss_cnt_reg + STAT_W'(1);
    end
  end

  assign frame_cnt_o = frame_cnt_reg;
  assign loss_cnt_o  = loss_cnt_reg;
`else
  assign frame_cnt_o = '0;
  assign loss_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_lock_search_ctrl.sv
// Directed bench for lock_search_ctrl with a frame-level lock/mode model checked every cycle.
module tb_lock_search_ctrl;
  localparam int MODE_W = 3, CNT_W = 4, DWELL = 4, TIMEOUT = 32, STAT_W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1, en_i = 1'b0, hist_val_i = 1'b0, calc_val_i = 1'b0, calc_lock_i = 1'b0;
  logic [CNT_W-1:0]  lock_thr_i = 4'd3, unlock_thr_i = 4'd2;
  logic              hist_rdy_o, hist_clr_o, calc_start_o, locked_o, timeout_o;
  logic [MODE_W-1:0] calc_mode_o, mode_o;
  logic [STAT_W-1:0] frame_cnt_o, loss_cnt_o;

  int checks = 0, errors = 0, frame_no = 0;
  bit chk_en = 1'b0;

  // Frame-level model: expected status after each evaluated frame.
  bit          exp_locked;
  logic [2:0]  exp_mode;
  int          hit_run, miss_run, exp_frames, exp_losses;

  lock_search_ctrl #(.MODE_W(MODE_W), .CNT_W(CNT_W), .DWELL(DWELL),
                     .TIMEOUT(TIMEOUT), .STAT_W(STAT_W)) dut (
    .clk(clk), .reset(reset), .en_i(en_i), .hist_val_i(hist_val_i),
    .hist_rdy_o(hist_rdy_o), .hist_clr_o(hist_clr_o), .calc_start_o(calc_start_o),
    .calc_mode_o(calc_mode_o), .calc_val_i(calc_val_i), .calc_lock_i(calc_lock_i),
    .lock_thr_i(lock_thr_i), .unlock_thr_i(unlock_thr_i), .locked_o(locked_o),
    .mode_o(mode_o), .timeout_o(timeout_o), .frame_cnt_o(frame_cnt_o), .loss_cnt_o(loss_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic checkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_locked = 1'b0; exp_mode = 3'b001;
    hit_run = 0; miss_run = 0; exp_frames = 0; exp_losses = 0;
  endtask

  task automatic model_disable();
    if (exp_locked) exp_losses++;
    exp_locked = 1'b0; hit_run = 0; miss_run = 0;
  endtask

  task automatic model_frame(input bit hit);
    int need_lock, need_unlock;
    need_lock   = (lock_thr_i == 0) ? 1 : int'(lock_thr_i);
    need_unlock = (unlock_thr_i == 0) ? 1 : int'(unlock_thr_i);
    exp_frames++;
    if (!exp_locked) begin
      if (hit) begin
        miss_run = 0;
        hit_run++;
        if (hit_run >= need_lock) begin exp_locked = 1'b1; hit_run = 0; end
      end else begin
        hit_run = 0;
        miss_run++;
        if (miss_run >= DWELL) begin
          exp_mode = (exp_mode == 3'b001) ? 3'b010 : 3'b001;
          miss_run = 0;
        end
      end
    end else if (hit) begin
      miss_run = 0;
    end else begin
      miss_run++;
      if (miss_run >= need_unlock) begin
        exp_locked = 1'b0; hit_run = 0; miss_run = 0; exp_losses++;
      end
    end
  endtask

  // Continuous comparison against the model on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check1("locked_o", locked_o, exp_locked);
      checkw("mode_o", 32'(mode_o), 32'(exp_mode));
      checkw("calc_mode_o", 32'(calc_mode_o), 32'(exp_mode));
`ifdef LOCK_SEARCH_STATS_EN
      checkw("frame_cnt_o", 32'(frame_cnt_o), 32'(exp_frames));
      checkw("loss_cnt_o", 32'(loss_cnt_o), 32'(exp_losses));
`else
      checkw("frame_cnt_o", 32'(frame_cnt_o), 32'd0);
      checkw("loss_cnt_o", 32'(loss_cnt_o), 32'd0);
`endif
    end
  end

  // Waits for hist_rdy_o, hands over a frame; returns in the START cycle.
  task automatic start_frame();
    int n = 0;
    while (hist_rdy_o !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    check1("hist_rdy_wait", hist_rdy_o, 1'b1);
    hist_val_i = 1'b1;
    @(posedge clk); #1;
    hist_val_i = 1'b0;
    check1("calc_start_o", calc_start_o, 1'b1);
    check1("hist_clr_o", hist_clr_o, 1'b1);
    checkw("calc_mode_at_start", 32'(calc_mode_o), 32'(exp_mode));
  endtask

  // lat > 0: calc_val_i arrives lat cycles after calc_start_o; lat <= 0: no answer.
  task automatic do_frame(input bit lock, input int lat);
    start_frame();
    if (lat > 0) begin
      for (int k = 1; k <= lat; k++) begin
        @(posedge clk); #1;
        check1("calc_start_pulse", calc_start_o, 1'b0);
      end
      calc_val_i = 1'b1; calc_lock_i = lock;
      @(posedge clk); #1;
      calc_val_i = 1'b0; calc_lock_i = 1'b0;
      check1("timeout_o_none", timeout_o, 1'b0);
      @(posedge clk); #1;
      check1("hist_rdy_after_upd", hist_rdy_o, 1'b1);
    end else begin
      for (int k = 1; k <= TIMEOUT; k++) begin
        @(posedge clk); #1;
        check1("timeout_o_at", timeout_o, k == TIMEOUT);
      end
      @(posedge clk); #1;
      check1("hist_rdy_after_to", hist_rdy_o, 1'b1);
      check1("timeout_o_single", timeout_o, 1'b0);
    end
    model_frame(lock && lat > 0);
    frame_no++;
    $display("frame %0d lock=%0b lat=%0d -> locked_o=%0b mode_o=%03b", frame_no, lock, lat, locked_o, mode_o);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check1("rst_hist_rdy", hist_rdy_o, 1'b0);
    check1("rst_calc_start", calc_start_o, 1'b0);
    check1("rst_hist_clr", hist_clr_o, 1'b0);
    check1("rst_timeout", timeout_o, 1'b0);
    check1("rst_locked", locked_o, 1'b0);
    checkw("rst_mode", 32'(mode_o), 32'd1);
    checkw("rst_calc_mode", 32'(calc_mode_o), 32'd1);
    reset = 1'b0;
    model_reset();
    chk_en = 1'b1;
    en_i = 1'b1;

    // Three hit frames with lock_thr 3
    do_frame(1'b1, 5);
    do_frame(1'b1, 5);
    check1("lit_not_yet_locked", locked_o, 1'b0);
    do_frame(1'b1, 5);
    check1("lit_locked_3hits", locked_o, 1'b1);
    checkw("lit_mode_fm4", 32'(mode_o), 32'd1);

    // Unlock hysteresis with unlock_thr 2: miss, hit, miss, miss
    do_frame(1'b0, 5);
    check1("lit_locked_after_1miss", locked_o, 1'b1);
    do_frame(1'b1, 2);
    do_frame(1'b0, 4);
    do_frame(1'b0, 6);
    check1("lit_unlocked", locked_o, 1'b0);
    checkw("lit_mode_kept", 32'(mode_o), 32'd1);
`ifdef LOCK_SEARCH_STATS_EN
    checkw("lit_loss_cnt", 32'(loss_cnt_o), 32'd1);
`endif

    // Four misses -> mode switch; lat 31 coincides with the last pre-timeout cycle
    do_frame(1'b0, 1);
    do_frame(1'b0, 31);
    do_frame(1'b0, 7);
    checkw("lit_mode_before_dwell", 32'(mode_o), 32'd1);
    do_frame(1'b0, 12);
    checkw("lit_mode_fm8", 32'(mode_o), 32'd2);
    checkw("lit_calc_mode_fm8", 32'(calc_mode_o), 32'd2);
    check1("lit_unlocked_dwell", locked_o, 1'b0);

    // No calculator answer
    do_frame(1'b1, 0);
    check1("lit_timeout_is_miss", locked_o, 1'b0);

    // lock_thr 0 behaves as 1
    lock_thr_i = 4'd0;
    do_frame(1'b1, 3);
    check1("lit_lock_thr0", locked_o, 1'b1);

    // Stray hist_val_i in WAIT_RES, then en_i dropped mid-frame
    start_frame();
    @(posedge clk); #1;
    @(posedge clk); #1;
    hist_val_i = 1'b1;
    @(posedge clk); #1;
    hist_val_i = 1'b0;
    check1("stray_hist_no_start", calc_start_o, 1'b0);
    check1("stray_hist_no_rdy", hist_rdy_o, 1'b0);
    en_i = 1'b0;
    @(posedge clk); #1;
    model_disable();
    check1("dis_locked", locked_o, 1'b0);
    checkw("dis_mode_held", 32'(mode_o), 32'd2);
    check1("dis_rdy", hist_rdy_o, 1'b0);
    calc_val_i = 1'b1; calc_lock_i = 1'b1;
    @(posedge clk); #1;
    calc_val_i = 1'b0; calc_lock_i = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check1("late_val_locked", locked_o, 1'b0);
      check1("late_val_timeout", timeout_o, 1'b0);
      check1("idle_rdy", hist_rdy_o, 1'b0);
    end
    en_i = 1'b1;
    @(posedge clk); #1;
    check1("reen_rdy", hist_rdy_o, 1'b1);
    $display("disable mid-frame -> locked_o=%0b mode_o=%03b", locked_o, mode_o);

    // Reset mid-frame; a late result must be ignored
    lock_thr_i = 4'd1;
    start_frame();
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check1("rst_mid_rdy", hist_rdy_o, 1'b0);
    checkw("rst_mid_mode", 32'(mode_o), 32'd1);
    @(posedge clk); #1;
    calc_val_i = 1'b1; calc_lock_i = 1'b1;
    @(posedge clk); #1;
    calc_val_i = 1'b0; calc_lock_i = 1'b0;
    check1("rst_late_rdy", hist_rdy_o, 1'b1);
    @(posedge clk); #1;
    check1("rst_late_locked", locked_o, 1'b0);
    $display("reset mid-frame -> locked_o=%0b mode_o=%03b", locked_o, mode_o);

    // Fresh lock after reset with lock_thr 1
    do_frame(1'b1, 3);
    check1("lit_final_locked", locked_o, 1'b1);
    checkw("lit_final_mode", 32'(mode_o), 32'd1);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end
endmodule
